fpu_ss_csr_ctx: RTL

FPU_SS_CSR_CTX -- requirements
Module: fpu_ss_csr_ctx

---
 rtl/fpu_ss_csr_ctx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fpu_ss_csr_ctx.sv
// Per-context fcsr file for an offloaded FPU subsystem. A CSR request waits for
// the in-flight FPU ops of its own context to drain before it reads or writes.
module fpu_ss_csr_ctx #(
   parameter  int unsigned NUM_CTX      = 2,
   parameter  int unsigned ID_WIDTH     = 4,
   parameter  int unsigned MAX_INFLIGHT = 4,
   localparam int unsigned CW           = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [31:0]         instr_i,
   input  logic [31:0]         csr_data_i,
   input  logic [CW-1:0]       csr_ctx_i,
   input  logic [ID_WIDTH-1:0] csr_id_i,
   output logic                csr_instr_o,
   input  logic                fpu_issue_valid_i,
   input  logic [CW-1:0]       fpu_issue_ctx_i,
   output logic                fpu_issue_ready_o,
   input  logic                fpu_out_valid_i,
   input  logic [CW-1:0]       fpu_out_ctx_i,
   input  logic [4:0]          fpu_status_i,
   input  logic [CW-1:0]       rm_ctx_i,
   output logic [2:0]          frm_o,
   output logic [2:0]          fmode_o,
   output logic                srm_o,
   output logic                wb_valid_o,
   input  logic                wb_ready_i,
   output logic [31:0]         wb_data_o,
   output logic [4:0]          wb_addr_o,
   output logic [ID_WIDTH-1:0] wb_id_o
);

   localparam int unsigned CNTW = $clog2(MAX_INFLIGHT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_EXEC, S_WB} state_e;
   typedef enum logic [1:0] {OP_NONE, OP_REG, OP_READ, OP_IMM} op_e;
   typedef enum logic [2:0] {FLD_NONE, FLD_FFLAGS, FLD_FRM, FLD_FCSR, FLD_FMODE, FLD_FSRM} field_e;

   // Only SYSTEM csrrw, csrrs with rs1 = x0 (pure read) and csrrwi are accepted.
   function automatic op_e decode_op(input logic [31:0] ins);
      decode_op = OP_NONE;
      if (ins[6:0] == 7'b1110011) begin
         case (ins[14:12])
            3'b001:  decode_op = OP_REG;
            3'b010:  decode_op = (ins[19:15] == 5'd0) ? OP_READ : OP_NONE;
            3'b101:  decode_op = OP_IMM;
            default: decode_op = OP_NONE;
         endcase
      end
   endfunction

   function automatic field_e decode_field(input logic [11:0] addr);
      case (addr)
         12'h001: decode_field = FLD_FFLAGS;
         12'h002: decode_field = FLD_FRM;
         12'h003: decode_field = FLD_FCSR;
         12'h800: decode_field = FLD_FMODE;
         12'h801: decode_field = FLD_FSRM;
         default: decode_field = FLD_NONE;
      endcase
   endfunction

   function automatic logic [11:0] field_mask(input field_e f);
      case (f)
         FLD_FFLAGS: field_mask = 12'h01F;
         FLD_FRM:    field_mask = 12'h0E0;
         FLD_FCSR:   field_mask = 12'hFFF;
         FLD_FMODE:  field_mask = 12'h700;
         FLD_FSRM:   field_mask = 12'h800;
         default:    field_mask = 12'h000;
      endcase
   endfunction

   function automatic logic [3:0] field_lsb(input field_e f);
      case (f)
         FLD_FRM:   field_lsb = 4'd5;
         FLD_FMODE: field_lsb = 4'd8;
         FLD_FSRM:  field_lsb = 4'd11;
         default:   field_lsb = 4'd0;
      endcase
   endfunction

   state_e                        state, state_next;
   logic [31:0]                   instr_reg;
   logic [11:0]                   data_reg;
   logic [CW-1:0]                 ctx_reg;
   logic [ID_WIDTH-1:0]           id_reg;
   logic [31:0]                   wb_data_reg;
   logic [NUM_CTX-1:0][11:0]      fcsr, fcsr_next;
   logic [NUM_CTX-1:0][CNTW-1:0]  cnt, cnt_next;

   logic [CNTW-1:0] req_cnt, srv_cnt, iss_cnt;
   logic [11:0]     srv_fcsr, rm_fcsr;
   logic            load, do_write, issue_fire;
   op_e             srv_op;
   field_e          srv_field;
   logic [11:0]     mask, wsrc, wval, old_field;
   logic [3:0]      lsb;
   logic            unused_data;

   assign unused_data = ^csr_data_i[31:12];

   always_comb begin
      req_cnt  = '0;
      srv_cnt  = '0;
      iss_cnt  = '0;
      srv_fcsr = '0;
      rm_fcsr  = '0;
      for (int unsigned i = 0; i < NUM_CTX; i++) begin
         if (csr_ctx_i == CW'(i))       req_cnt  = cnt[i];
         if (ctx_reg == CW'(i))         srv_cnt  = cnt[i];
         if (fpu_issue_ctx_i == CW'(i)) iss_cnt  = cnt[i];
         if (ctx_reg == CW'(i))         srv_fcsr = fcsr[i];
         if (rm_ctx_i == CW'(i))        rm_fcsr  = fcsr[i];
      end
   end

   assign csr_instr_o = (decode_op(instr_i) != OP_NONE) &&
                        (decode_field(instr_i[31:20]) != FLD_NONE);

   assign fpu_issue_ready_o = (iss_cnt < CNTW'(MAX_INFLIGHT)) &&
                              !((state != S_IDLE) && (fpu_issue_ctx_i == ctx_reg));
   assign issue_fire = fpu_issue_valid_i && fpu_issue_ready_o;

   assign in_ready_o = (state == S_IDLE);
   assign load       = in_ready_o && in_valid_i && csr_instr_o;

   assign srv_op    = decode_op(instr_reg);
   assign srv_field = decode_field(instr_reg[31:20]);
   assign mask      = field_mask(srv_field);
   assign lsb       = field_lsb(srv_field);
   assign old_field = (srv_fcsr & mask) >> lsb;
   assign wsrc      = (srv_op == OP_IMM) ? {7'd0, instr_reg[19:15]} : data_reg;
   assign wval      = (wsrc << lsb) & mask;
   assign do_write  = (state == S_EXEC) && ((srv_op == OP_REG) || (srv_op == OP_IMM));

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (load) state_next = (req_cnt != '0) ? S_DRAIN : S_EXEC;
         S_DRAIN: if (srv_cnt == '0) state_next = S_EXEC;
         S_EXEC:  state_next = (srv_op == OP_IMM) ? S_IDLE : S_WB;
         S_WB:    if (wb_ready_i) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Sticky status OR lands first so a same-cycle CSR write of fflags wins in its own context.
   always_comb begin
      fcsr_next = fcsr;
      cnt_next  = cnt;
      for (int unsigned i = 0; i < NUM_CTX; i++) begin
         if (fpu_out_valid_i && (fpu_out_ctx_i == CW'(i)))
            fcsr_next[i][4:0] = fcsr[i][4:0] | fpu_status_i;
         if (do_write && (ctx_reg == CW'(i)))
            fcsr_next[i] = (fcsr_next[i] & ~mask) | wval;
         if (issue_fire && (fpu_issue_ctx_i == CW'(i))) begin
            if (!(fpu_out_valid_i && (fpu_out_ctx_i == CW'(i))))
               cnt_next[i] = cnt[i] + 1'b1;
         end else if (fpu_out_valid_i && (fpu_out_ctx_i == CW'(i)) && (cnt[i] != '0)) begin
            cnt_next[i] = cnt[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= S_IDLE;
         instr_reg   <= '0;
         data_reg    <= '0;
         ctx_reg     <= '0;
         id_reg      <= '0;
         wb_data_reg <= '0;
         fcsr        <= '0;
         cnt         <= '0;
      end else begin
         state <= state_next;
         fcsr  <= fcsr_next;
         cnt   <= cnt_next;
         if (load) begin
            instr_reg <= instr_i;
            data_reg  <= csr_data_i[11:0];
            ctx_reg   <= csr_ctx_i;
            id_reg    <= csr_id_i;
         end
         if (state == S_EXEC) wb_data_reg <= {20'd0, old_field};
      end
   end

   assign frm_o      = rm_fcsr[7:5];
   assign fmode_o    = rm_fcsr[10:8];
   assign srm_o      = rm_fcsr[11];
   assign wb_valid_o = (state == S_WB);
   assign wb_data_o  = wb_data_reg;
   assign wb_addr_o  = instr_reg[11:7];
   assign wb_id_o    = id_reg;

endmodule
